packet_mem_to_tx: RTL

- Downstream stage of the packet buffer. It pops committed packet lengths from the length FIFO and reads the matching bytes from the packet SRAM, a circular buffer.
- It replays each packet as an 8-bit GMII-style transmit stream, with a programmable inter-frame gap.
- It returns the committed read pointer so the upstream writer can compute free space.

---
 rtl/copy_mem_pkg.sv | 25 ++
 rtl/ring_ptr_adv.sv | 34 +++
 rtl/packet_mem_to_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/copy_mem_pkg.sv
// Shared definitions for the packet-buffer writer and reader stages:
// FSM encoding, buffer geometry and the circular-pointer increment.
package copy_mem_pkg;

    localparam int unsigned pDATA_WIDTH = 8;
    localparam int unsigned pLEN_WIDTH  = 16;
    localparam int unsigned pDEPTH_RAM  = 3072;
    localparam int unsigned pADDR_WIDTH = $clog2(pDEPTH_RAM);
    localparam int unsigned pMAX_LEN    = 1536;
    localparam int unsigned pIFG        = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        SEND  = 3'd2,
        IFG   = 3'd3,
        DROP  = 3'd4
    } state_t;

    // Depth need not be a power of two, so wrap explicitly at depth-1.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ring_ptr_adv.sv
// Registered circular pointer with load and increment, wrapping at pDEPTH.
// Load takes priority over increment.
module ring_ptr_adv
    import copy_mem_pkg::*;
#(
    parameter int unsigned pDEPTH = copy_mem_pkg::pDEPTH_RAM,
    parameter int unsigned pWIDTH = $clog2(pDEPTH)
) (
    input  logic              iclk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [pWIDTH-1:0] i_load_val,
    input  logic              i_inc,
    output logic [pWIDTH-1:0] o_ptr
);

    logic [pWIDTH-1:0] r_ptr;
    logic [pWIDTH-1:0] w_ptr_nxt;

    assign w_ptr_nxt = pWIDTH'(wrap_inc(32'(r_ptr), pDEPTH));

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/packet_mem_to_tx.sv
// Reader stage of the packet buffer: pops committed lengths, replays the bytes
// from the circular SRAM as a GMII-style stream and commits the read pointer.
module packet_mem_to_tx #(
    parameter int unsigned pDATA_WIDTH = copy_mem_pkg::pDATA_WIDTH,
    parameter int unsigned pLEN_WIDTH  = copy_mem_pkg::pLEN_WIDTH,
    parameter int unsigned pDEPTH_RAM  = copy_mem_pkg::pDEPTH_RAM,
    parameter int unsigned pADDR_WIDTH = $clog2(pDEPTH_RAM),
    parameter int unsigned pMAX_LEN    = copy_mem_pkg::pMAX_LEN,
    parameter int unsigned pIFG        = copy_mem_pkg::pIFG
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   i_tx_enable,
    input  logic                   i_len_empty,
    input  logic [pLEN_WIDTH-1:0]  i_len_data,
    output logic                   o_len_rd,
    output logic [pADDR_WIDTH-1:0] o_ram_addr,
    input  logic [pDATA_WIDTH-1:0] i_ram_data,
    output logic                   otx_en,
    output logic [pDATA_WIDTH-1:0] otx_d,
    output logic                   otx_er,
    output logic [pADDR_WIDTH-1:0] o_rd_ptr_succ,
    output logic                   o_pkt_done,
    output logic                   o_len_err,
    output logic                   o_busy
);

    import copy_mem_pkg::state_t;
    import copy_mem_pkg::IDLE;
    import copy_mem_pkg::PRIME;
    import copy_mem_pkg::SEND;
    import copy_mem_pkg::IFG;
    import copy_mem_pkg::DROP;
    import copy_mem_pkg::wrap_inc;

    state_t                 r_state, w_state_nxt;
    logic [pLEN_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic                   r_len_rd, r_len_err, r_pkt_done;
    logic [pADDR_WIDTH-1:0] r_rd_ptr_succ;
    logic                   w_pop, w_err, w_done, w_commit;
    logic [pADDR_WIDTH-1:0] w_rd_ptr, w_rd_ptr_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                // A pop still in flight means the FIFO head is stale this cycle.
                if (!i_len_empty && i_tx_enable && !r_len_rd) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = i_len_data;
                    if (i_len_data == '0) begin
                        w_state_nxt = IDLE;
                    end else if (i_len_data > pLEN_WIDTH'(pMAX_LEN)) begin
                        w_state_nxt = DROP;
                        w_err       = 1'b1;
                    end else begin
                        w_state_nxt = PRIME;
                    end
                end
            end
            PRIME: w_state_nxt = SEND;
            SEND: begin
                w_cnt_nxt = r_cnt - pLEN_WIDTH'(1);
                if (r_cnt == pLEN_WIDTH'(1)) begin
                    w_state_nxt = (pIFG == 0) ? IDLE : IFG;
                    w_cnt_nxt   = pLEN_WIDTH'(pIFG);
                    w_done      = 1'b1;
                    w_commit    = 1'b1;
                end
            end
            IFG: begin
                w_cnt_nxt = r_cnt - pLEN_WIDTH'(1);
                if (r_cnt == pLEN_WIDTH'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                w_cnt_nxt = r_cnt - pLEN_WIDTH'(1);
                if (r_cnt == pLEN_WIDTH'(1)) begin
                    w_state_nxt = IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_len_rd      <= 1'b0;
            r_len_err     <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_rd_ptr_succ <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len_rd   <= w_pop;
            r_len_err  <= w_err;
            r_pkt_done <= w_done;
            if (w_commit) begin
                r_rd_ptr_succ <= w_rd_ptr_nxt;
            end
        end
    end

    // The commit edge is also the pointer's last advance, so commit its next value.
    assign w_rd_ptr_nxt = pADDR_WIDTH'(wrap_inc(32'(w_rd_ptr), pDEPTH_RAM));

    ring_ptr_adv #(
        .pDEPTH (pDEPTH_RAM),
        .pWIDTH (pADDR_WIDTH)
    ) u_rd_ptr (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      ((r_state == SEND) || (r_state == DROP)),
        .o_ptr      (w_rd_ptr)
    );

    // Address runs one byte ahead of the consumed pointer to hide SRAM latency.
    ring_ptr_adv #(
        .pDEPTH (pDEPTH_RAM),
        .pWIDTH (pADDR_WIDTH)
    ) u_ram_addr (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .i_load     (r_state == IDLE),
        .i_load_val (w_rd_ptr),
        .i_inc      ((r_state == PRIME) || (r_state == SEND)),
        .o_ptr      (o_ram_addr)
    );

    assign otx_en        = (r_state == SEND);
    assign otx_d         = (r_state == SEND) ? i_ram_data : '0;
    assign otx_er        = 1'b0;
    assign o_len_rd      = r_len_rd;
    assign o_len_err     = r_len_err;
    assign o_pkt_done    = r_pkt_done;
    assign o_rd_ptr_succ = r_rd_ptr_succ;
    assign o_busy        = (r_state != IDLE);

endmodule
